spi_controller: RTL and testbench

Controller (initiator) end of the chip's SPI register link: generates `sclk`, shifts an address byte followed by N data bytes out on `pico` MSB first, and captures `poci` read-back bits. It runs on the internal clock and is used by the test/readout harness to write the trigger channel mask, instruction, mode and analog registers. It enforces an sclk-idle gap after every transaction so the peripheral's sclk-stop detector resets its address pointer before the next transaction starts.

---
 rtl/spi_controller.sv | 204 ++++++++++++++++++++
 tb/tb_spi_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI initiator (mode 0) for the chip register link. Shifts an
//               address byte followed by num_bytes data bytes out on pico,
//               MSB first. Captures poci read-back bits on each sclk rising
//               edge. Holds sclk low for GAP_CYCLES after the last bit, so
//               that the peripheral's sclk-stop detector rearms before the
//               next transaction starts.
//
// Ports       : iclk      - sole clock (rising edge)
//               rstn      - asynchronous active-low reset
//               start     - transaction request, sampled only when idle
//               addr      - start address, captured on accepted start
//               num_bytes - data bytes after the address (0..63)
//               tx_data   - next data byte to send
//               tx_ack    - pulse: tx_data loaded into the shift register
//               rx_data   - last completed received data byte
//               rx_valid  - pulse: rx_data updated
//               busy      - transaction or gap in progress
//               done      - pulse at the end of the gap
//               sclk      - SPI clock, idle low
//               pico      - serial data to the peripheral
//               poci      - serial data from the peripheral
//
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       iclk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [5:0] num_bytes,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       pico,
    input  logic       poci
);

    // The extra +1 keeps both widths at least one bit when a parameter is 1.
    localparam int c_HALF_W = $clog2(CLK_DIV + 1);
    localparam int c_GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [c_HALF_W-1:0]  half_q,    half_d;
    logic [c_GAP_W-1:0]   gap_q,     gap_d;
    logic [2:0]           bit_q,     bit_d;
    logic [5:0]           byte_q,    byte_d;
    logic [5:0]           nbytes_q,  nbytes_d;
    logic [7:0]           tx_sr_q,   tx_sr_d;
    logic [7:0]           rx_sr_q,   rx_sr_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 sclk_q,    sclk_d;
    logic                 tx_ack_q,  tx_ack_d;
    logic                 rx_val_q,  rx_val_d;
    logic                 done_q,    done_d;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            half_q    <= '0;
            gap_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            nbytes_q  <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            tx_ack_q  <= 1'b0;
            rx_val_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            gap_q     <= gap_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            nbytes_q  <= nbytes_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            tx_ack_q  <= tx_ack_d;
            rx_val_q  <= rx_val_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        nbytes_d  = nbytes_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        tx_ack_d  = 1'b0;
        rx_val_d  = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d = 1'b0;
                if (start) begin
                    nbytes_d = num_bytes;
                    tx_sr_d  = addr;   // pico shows addr[7] from this edge on
                    rx_sr_d  = '0;
                    half_d   = '0;
                    bit_d    = '0;
                    byte_d   = '0;
                    state_d  = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (half_q == c_HALF_LAST) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        // Rising half: sample the peripheral's bit.
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], poci};
                    end else begin
                        // Falling half: advance pico to the next bit.
                        sclk_d  = 1'b0;
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            bit_d = '0;
                            // Byte 0 is the address; its read-back is dropped.
                            if (byte_q != 6'd0) begin
                                rx_data_d = rx_sr_q;
                                rx_val_d  = 1'b1;
                            end
                            if (byte_q == nbytes_q) begin
                                tx_sr_d = '0;
                                gap_d   = '0;
                                state_d = S_GAP;
                            end else begin
                                tx_sr_d  = tx_data;
                                tx_ack_d = 1'b1;
                                byte_d   = byte_q + 6'd1;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    half_d = half_q + c_HALF_W'(1);
                end
            end

            S_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + c_GAP_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign busy     = (state_q != S_IDLE);
    assign sclk     = sclk_q;
    assign pico     = tx_sr_q[7];
    assign tx_ack   = tx_ack_q;
    assign rx_valid = rx_val_q;
    assign rx_data  = rx_data_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Self-checking bench for spi_controller. Transactions are
//               described as byte lists. The expected pulse times and values,
//               and the expected pico bit stream, are derived from the
//               transaction timing rules and queued. A negedge monitor pops
//               and compares each pulse as the DUT presents it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int D = 2;
    localparam int G = 16;

    logic       iclk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [5:0] num_bytes = 6'd0;
    logic [7:0] tx_data = 8'h00;
    logic       poci = 1'b0;
    logic       tx_ack, rx_valid, busy, done, sclk, pico;
    logic [7:0] rx_data;

    spi_controller #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
        .iclk(iclk), .rstn(rstn), .start(start), .addr(addr),
        .num_bytes(num_bytes), .tx_data(tx_data), .tx_ack(tx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .sclk(sclk), .pico(pico), .poci(poci)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endfunction

    // Scoreboard state
    int         exp_ack_q[$];
    int         exp_rx_cyc_q[$];
    logic [7:0] exp_rx_val_q[$];
    int         exp_done_q[$];
    bit         exp_bits[$];
    bit         got_bits[$];
    bit         resp_bits[$];
    logic [7:0] txbytes[$];
    int         rise_idx = 0;
    logic       sclk_prev = 1'b0;
    bit         done_seen = 1'b0;
    int         done_cyc = 0;

    // Transaction description filled by the stimulus before each launch
    logic [7:0] tb_data[$];
    logic [7:0] tb_resp[$];

    // ------------------------------------------------------------------------
    // Monitor: pulses, pico capture and peripheral (poci) model
    // ------------------------------------------------------------------------
    always @(negedge iclk) begin
        if (tx_ack) begin
            if (exp_ack_q.size() == 0) fail_now("tx_ack_unexpected");
            else chk("tx_ack_time", cyc, exp_ack_q.pop_front());
            if (txbytes.size() > 0) void'(txbytes.pop_front());
            tx_data = (txbytes.size() > 0) ? txbytes[0] : $urandom_range(0, 255);
        end
        if (rx_valid) begin
            if (exp_rx_cyc_q.size() == 0) fail_now("rx_valid_unexpected");
            else begin
                chk("rx_valid_time", cyc, exp_rx_cyc_q.pop_front());
                chk("rx_data", int'(rx_data), int'(exp_rx_val_q.pop_front()));
            end
        end
        if (done) begin
            if (exp_done_q.size() == 0) fail_now("done_unexpected");
            else begin
                chk("done_time", cyc, exp_done_q.pop_front());
                chk("done_busy_low", int'(busy), 0);
            end
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (sclk && !sclk_prev) begin
            got_bits.push_back(pico);
            rise_idx++;
            poci = (rise_idx < resp_bits.size()) ? resp_bits[rise_idx] : 1'b0;
        end
        sclk_prev = sclk;
    end

    task automatic fill_resp(input int n);
        tb_resp.delete();
        for (int i = 0; i <= n; i++) tb_resp.push_back(8'($urandom_range(0, 255)));
    endtask

    // Start a transaction and queue its expected behaviour.
    task automatic launch(input logic [7:0] a, input bit hold, input bit chained,
                          output int e0);
        int n;
        n = tb_data.size();
        if (!chained) begin
            repeat ($urandom_range(1, 3)) @(negedge iclk);
            #1;
        end
        exp_bits.delete();
        resp_bits.delete();
        got_bits.delete();
        for (int b = 7; b >= 0; b--) exp_bits.push_back(a[b]);
        foreach (tb_data[i]) for (int b = 7; b >= 0; b--) exp_bits.push_back(tb_data[i][b]);
        foreach (tb_resp[i]) for (int b = 7; b >= 0; b--) resp_bits.push_back(tb_resp[i][b]);
        rise_idx  = 0;
        poci      = resp_bits[0];
        txbytes   = tb_data;
        tx_data   = (n > 0) ? tb_data[0] : 8'h00;
        addr      = a;
        num_bytes = 6'(n);
        start     = 1'b1;
        done_seen = 1'b0;
        @(posedge iclk);
        #1;
        e0 = cyc;
        if (chained) chk("chain_accept_cycle", e0, done_cyc + 1);
        chk("e0_busy", int'(busy), 1);
        chk("e0_sclk", int'(sclk), 0);
        chk("e0_pico", int'(pico), int'(a[7]));
        if (!hold) start = 1'b0;
        // Scramble the captured inputs to prove they were latched.
        addr      = 8'($urandom_range(0, 255));
        num_bytes = 6'($urandom_range(0, 63));
        for (int k = 0; k < n; k++) exp_ack_q.push_back(e0 + 16 * (k + 1) * D);
        for (int k = 1; k <= n; k++) begin
            exp_rx_cyc_q.push_back(e0 + 16 * (k + 1) * D);
            exp_rx_val_q.push_back(tb_resp[k]);
        end
        exp_done_q.push_back(e0 + 16 * (1 + n) * D + G);
    endtask

    // Wait for done and compare the collected stream against the model.
    task automatic finish_txn(input int e0);
        int lim;
        int bad;
        lim = 16 * (1 + tb_data.size()) * D + G + 20;
        for (int i = 0; i < lim; i++) begin
            @(negedge iclk);
            #1;
            if (done_seen) break;
        end
        if (!done_seen) fail_now("done_timeout");
        chk("rising_edge_count", got_bits.size(), exp_bits.size());
        bad = 0;
        foreach (exp_bits[i]) if (i >= got_bits.size() || got_bits[i] != exp_bits[i]) bad++;
        chk("pico_stream_bad_bits", bad, 0);
        chk("leftover_tx_ack", exp_ack_q.size(), 0);
        chk("leftover_rx_valid", exp_rx_cyc_q.size(), 0);
        chk("leftover_done", exp_done_q.size(), 0);
        exp_ack_q.delete();
        exp_rx_cyc_q.delete();
        exp_rx_val_q.delete();
        exp_done_q.delete();
        if (e0 < 0) fail_now("bad_e0");
    endtask

    task automatic run_txn(input logic [7:0] a, input bit hold, input bit chained);
        int e0;
        launch(a, hold, chained, e0);
        finish_txn(e0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int target;
        rstn = 1'b0;
        repeat (3) @(negedge iclk);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_pico", int'(pico), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tx_ack", int'(tx_ack), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        rstn = 1'b1;

        // Write one byte
        tb_data = '{8'hA5};
        fill_resp(1);
        run_txn(8'h01, 1'b0, 1'b0);

        // Read one byte: peripheral returns 0x3C
        tb_data = '{8'h00};
        fill_resp(1);
        tb_resp[1] = 8'h3C;
        run_txn(8'h04, 1'b0, 1'b0);

        // Burst of seven bytes
        tb_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        fill_resp(7);
        run_txn(8'h04, 1'b0, 1'b0);

        // Address only
        tb_data.delete();
        fill_resp(0);
        run_txn(8'h02, 1'b0, 1'b0);

        // start held high for a whole transaction, then chained acceptance
        tb_data = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        fill_resp(2);
        run_txn(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        tb_data = '{8'($urandom_range(0, 255))};
        fill_resp(1);
        run_txn(8'($urandom_range(0, 255)), 1'b0, 1'b1);

        // Reset during bit 3 of the first data byte
        tb_data = '{8'h5A, 8'hC3};
        fill_resp(2);
        launch(8'h81, 1'b0, 1'b0, e0);
        target = e0 + (16 + 2 * 3 + 1) * D;
        for (int i = 0; i < 200 && cyc <= target; i++) @(negedge iclk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_sclk", int'(sclk), 0);
        chk("midrst_pico", int'(pico), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rx_valid", int'(rx_valid), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_rx_data", int'(rx_data), 0);
        exp_ack_q.delete();
        exp_rx_cyc_q.delete();
        exp_rx_val_q.delete();
        exp_done_q.delete();
        repeat (3) @(negedge iclk);
        rstn = 1'b1;
        repeat (4) @(negedge iclk);
        chk("postrst_busy", int'(busy), 0);

        tb_data = '{8'h96, 8'h69};
        fill_resp(2);
        run_txn(8'h10, 1'b0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            int n;
            n = (t == 7) ? 20 : $urandom_range(0, 5);
            tb_data.delete();
            for (int i = 0; i < n; i++) tb_data.push_back(8'($urandom_range(0, 255)));
            fill_resp(n);
            run_txn(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        repeat (5) @(negedge iclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
